// File: rtl/arb_pkg.sv
// Shared types and sizing for the aging burst arbiter and its pick logic.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam int unsigned N_REQ_DEF  = 3;
  localparam int unsigned PRIO_W_DEF = 3;
  localparam int unsigned AGE_W_DEF  = 4;
  localparam int unsigned IDX_W      = 2;

  function automatic int unsigned eff_width(input int unsigned prio_w, input int unsigned age_w);
    return ((prio_w > age_w) ? prio_w : age_w) + 1;
  endfunction

  localparam int unsigned EFF_W = eff_width(PRIO_W_DEF, AGE_W_DEF);

  // Round-robin successor over the three requester slots.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: highest effective priority among requesters,
// ties resolved by scan order starting just after rr_ptr.
module arb_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned EW    = EFF_W
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0][EW-1:0] eff,
  input  logic [IDX_W-1:0]         rr_ptr,
  output logic [IDX_W-1:0]         winner,
  output logic                     any_valid
);

  logic [IDX_W-1:0] idx;
  logic [EW-1:0]    best;

  // Strict '>' keeps the earliest tied source in scan order.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    best      = '0;
    idx       = next_idx(rr_ptr);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (req[idx] && (!any_valid || eff[idx] > best)) begin
        winner    = idx;
        best      = eff[idx];
        any_valid = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

endmodule

// File: rtl/aging_burst_arbiter.sv
// Three-way burst arbiter: programmed priority plus aging bonus, round-robin
// tie break, burst hold with early release and a one-cycle turnaround gap.
module aging_burst_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned PRIO_W    = PRIO_W_DEF,
  parameter int unsigned AGE_W     = AGE_W_DEF,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*PRIO_W-1:0]  prios,
  input  logic                     beat,
  // 'release' is a reserved word, so the early-end input carries this name.
  input  logic                     release_burst,
  output logic [N_REQ-1:0]         gnt,
  output logic                     valid,
  output logic [IDX_W-1:0]         owner,
  output logic                     busy
);

  localparam int unsigned EW   = eff_width(PRIO_W, AGE_W);
  localparam int unsigned BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t                       state, state_n;
  logic [IDX_W-1:0]             rr_ptr;
  logic [BC_W-1:0]              beat_cnt;
  logic [N_REQ-1:0][AGE_W-1:0]  age;
  logic [N_REQ-1:0][EW-1:0]     eff;
  logic [IDX_W-1:0]             win;
  logic                         any;
  logic                         do_grant, do_exit, last_beat;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++)
      eff[i] = EW'(prios[i*PRIO_W +: PRIO_W]) + EW'(age[i]);
  end

  arb_pick #(.N_REQ(N_REQ), .EW(EW)) u_pick (
    .req       (req),
    .eff       (eff),
    .rr_ptr    (rr_ptr),
    .winner    (win),
    .any_valid (any)
  );

  assign last_beat = (beat_cnt == BC_W'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_grant = 1'b0;
    do_exit  = 1'b0;
    unique case (state)
      IDLE: if (any) begin
        state_n  = GRANT;
        do_grant = 1'b1;
      end
      GRANT: if (release_burst || !req[owner] || (beat && last_beat)) begin
        state_n = GAP;
        do_exit = 1'b1;
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= 2'd2;
      beat_cnt <= '0;
      age      <= '0;
    end else begin
      if (do_grant) begin
        gnt      <= N_REQ'(1) << win;
        owner    <= win;
        rr_ptr   <= win;
        beat_cnt <= '0;
      end else if (do_exit) begin
        gnt   <= '0;
        owner <= '0;
      end else if (state == GRANT && beat) begin
        beat_cnt <= beat_cnt + BC_W'(1);
      end
      // Ages freeze across the turnaround gap; the current owner never ages.
      if (state != GAP) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (!req[i] || (do_grant && win == IDX_W'(i)))
            age[i] <= '0;
          else if (!gnt[i] && age[i] != '1)
            age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end

  assign valid = |gnt;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_aging_burst_arbiter.sv
// Directed bench for aging_burst_arbiter with a cycle-level reference model.
module tb_aging_burst_arbiter;

  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [8:0] prios;
  logic       beat;
  logic       release_burst;
  logic [2:0] gnt;
  logic       valid;
  logic [1:0] owner;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  aging_burst_arbiter #(.N_REQ(3), .PRIO_W(3), .AGE_W(4), .MAX_BURST(MAXB)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .prios         (prios),
    .beat          (beat),
    .release_burst (release_burst),
    .gnt           (gnt),
    .valid         (valid),
    .owner         (owner),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: owner index (-1 = none), gap flag, ages as plain ints.
  int m_own, m_ptr, m_beats;
  bit m_gap;
  int m_age[3];

  function automatic int mprio(input int i);
    return int'(prios >> (3 * i)) & 7;
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 2; m_beats = 0; m_gap = 0;
    for (int i = 0; i < 3; i++) m_age[i] = 0;
  endtask

  task automatic model_step();
    int w, best, idx;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_own < 0) begin
      w = -1; best = -1;
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + 1 + k) % 3;
        if (req[idx] && (mprio(idx) + m_age[idx] > best)) begin
          best = mprio(idx) + m_age[idx];
          w = idx;
        end
      end
      for (int i = 0; i < 3; i++)
        m_age[i] = (!req[i] || i == w) ? 0 : ((m_age[i] < 15) ? m_age[i] + 1 : 15);
      if (w >= 0) begin
        m_own = w; m_ptr = w; m_beats = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++)
        if (!req[i]) m_age[i] = 0;
        else if (i != m_own) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
      if (beat) m_beats++;
      if (release_burst || !req[m_own] || m_beats == MAXB) begin
        m_own = -1; m_gap = 1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    check("gnt",   int'(gnt),   (m_own >= 0) ? (1 << m_own) : 0);
    check("valid", int'(valid), (m_own >= 0) ? 1 : 0);
    check("owner", int'(owner), (m_own >= 0) ? m_own : 0);
    check("busy",  int'(busy),  (m_own >= 0 || m_gap) ? 1 : 0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req = '0; beat = 0; release_burst = 0;
    @(negedge clk);
    rst = 0;
  endtask

  int q[$];
  int n0;
  bit found, prev_v;

  initial begin
    rst = 1; req = '0; prios = '0; beat = 0; release_burst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_owner", int'(owner), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);

    // Single requester, full burst, then re-grant after gap.
    @(negedge clk); req = 3'b010;
    @(posedge clk); #2;
    check("single_gnt", int'(gnt), 3'b010);
    check("single_owner", int'(owner), 1);
    @(negedge clk); beat = 1;
    repeat (8) @(posedge clk); #2;
    check("burst_end_gnt", int'(gnt), 0);
    check("burst_end_busy", int'(busy), 1);
    @(negedge clk); beat = 0;
    @(posedge clk); #2;
    check("after_gap_busy", int'(busy), 0);
    @(posedge clk); #2;
    check("regrant_gnt", int'(gnt), 3'b010);

    // Priority win; mid-burst priority change has no effect.
    do_reset();
    prios = {3'd1, 3'd5, 3'd2}; req = 3'b111;
    @(posedge clk); #2;
    check("prio_gnt", int'(gnt), 3'b010);
    @(negedge clk); prios = {3'd7, 3'd0, 3'd7};
    repeat (2) @(posedge clk); #2;
    check("prio_hold_gnt", int'(gnt), 3'b010);

    // Round-robin among equal priorities, release every grant.
    do_reset();
    prios = {3'd3, 3'd3, 3'd3}; req = 3'b111; release_burst = 1;
    q.delete(); prev_v = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #2;
      if (valid && !prev_v) q.push_back(int'(owner));
      prev_v = valid;
    end
    check("rr_count", (q.size() >= 4) ? 1 : 0, 1);
    if (q.size() >= 4) begin
      check("rr_0", q[0], 0);
      check("rr_1", q[1], 1);
      check("rr_2", q[2], 2);
      check("rr_3", q[3], 0);
    end

    // Aging: low-priority source 2 wins after four grants to source 0.
    do_reset();
    prios = {3'd0, 3'd0, 3'd7}; req = 3'b101; release_burst = 1;
    n0 = 0; found = 0; prev_v = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #2;
      if (valid && !prev_v) begin
        if (owner == 2'd2) found = 1;
        else if (owner == 2'd0) n0++;
      end
      prev_v = valid;
    end
    check("aging_found", int'(found), 1);
    check("aging_n0", n0, 4);

    // Owner drops req after three beats.
    do_reset();
    prios = '0; req = 3'b001;
    @(posedge clk);
    @(negedge clk); beat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); beat = 0; req = 3'b000;
    @(posedge clk); #2;
    check("drop_gnt", int'(gnt), 0);
    check("drop_busy", int'(busy), 1);

    // Release together with the last beat: a single gap cycle.
    do_reset();
    req = 3'b100;
    @(posedge clk);
    @(negedge clk); beat = 1;
    repeat (7) @(posedge clk);
    @(negedge clk); release_burst = 1;
    @(posedge clk); #2;
    check("last_rel_gnt", int'(gnt), 0);
    check("last_rel_busy", int'(busy), 1);
    @(negedge clk); release_burst = 0; beat = 0;
    @(posedge clk); #2;
    check("last_rel_idle", int'(busy), 0);
    @(posedge clk); #2;
    check("last_rel_regrant", int'(gnt), 3'b100);

    // Asynchronous reset mid-grant.
    do_reset();
    prios = {3'd2, 3'd2, 3'd2}; req = 3'b100;
    @(posedge clk);
    @(negedge clk); #2; rst = 1;
    #1;
    check("async_gnt", int'(gnt), 0);
    check("async_owner", int'(owner), 0);
    check("async_busy", int'(busy), 0);
    @(negedge clk); rst = 0; req = 3'b111;
    @(posedge clk); #2;
    check("post_rst_tie", int'(gnt), 3'b001);

    repeat (2) @(posedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aging_burst_arbiter.md
# aging_burst_arbiter

- Shares one downstream resource between 3 requesters; one grant is held for a burst of transfer beats.
- Winner is the highest effective priority: programmed priority plus an aging bonus, so low-priority requesters are never starved.
- Ties are broken round-robin.
- Sits between the requesting sources and the shared datapath, in the same slot as the existing priority arbiter, extended with burst hold, aging and release.

## Interface
- `N_REQ`, 3, number of requesters (fixed at 3 in this revision)
- `PRIO_W`, 3, programmed priority width per requester
- `AGE_W`, 4, age counter width per requester
- `MAX_BURST`, 8, maximum beats per grant (≥1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  3  request per source, level
- `prios`  in  9  source0 = [2:0], source1 = [5:3], source2 = [8:6]; sampled each arbitration
- `beat`  in  1  owner completed one transfer this cycle; ignored unless in GRANT
- `release`  in  1  owner ends burst early; ignored unless in GRANT
- `gnt`  out  3  one-hot grant, registered
- `valid`  out  1  equals |gnt
- `owner`  out  2  index of granted source; 0 when `valid` is 0
- `busy`  out  1  high in GRANT and GAP

## Operation
Effective priority
- eff[i] = {2'b0, prio[i]} + {1'b0, age[i]}, 5 bits, no overflow possible.
- Only sources with req[i] = 1 compete.

Winner selection
- Highest eff wins.
- On equal eff, scan order starts at (rr_ptr + 1) mod 3; first tied source wins.

Age counters
- In IDLE and GRANT, age[i] increments each cycle that req[i] = 1 and source i is not the owner; saturates at 2^AGE_W − 1.
- age[i] clears when source i is granted.
- age[i] clears when req[i] = 0.
- Ages hold during GAP.

FSM states
- IDLE
  - gnt = 0.
  - If |req, register winner: gnt ← onehot(w), owner ← w, rr_ptr ← w, beat_cnt ← 0; go to GRANT.
- GRANT
  - gnt is held.
  - beat increments beat_cnt.
  - Exit to GAP on the first cycle with any of:
    - release = 1
    - req[owner] = 0
    - beat = 1 with beat_cnt = MAX_BURST − 1
  - On exit, gnt ← 0 and owner ← 0, registered at the same edge.
- GAP
  - One idle cycle, gnt = 0; always go to IDLE.
  - Guarantees a grant-free turnaround cycle between owners.

Boundary conditions
- Simultaneous beat and release on the last beat: a single exit; no extra state.
- Owner re-requests after GAP: competes normally. Its age is 0, so equal-priority rivals win via round-robin.
- MAX_BURST = 1: first beat ends the grant.
- All req dropped in IDLE: stay in IDLE.
- prios change during GRANT: no effect until the next IDLE arbitration.
- Reset mid-burst: all state clears immediately (async); gnt drops without waiting for a clock.

Reset values
- gnt = 0, valid = 0, owner = 0, busy = 0.
- state = IDLE, beat_cnt = 0, all ages = 0.
- rr_ptr = 2, so source 0 wins the first tie.

## Timing
- Arbitration latency: req sampled at edge k gives gnt valid after edge k (same edge registers it); 1 cycle from req assertion to gnt.
- Burst end: the edge that samples the terminating condition deasserts gnt.
- Minimum spacing between grants is 2 cycles of gnt low: the GAP cycle plus the IDLE arbitration edge.
- Back-to-back throughput is therefore MAX_BURST beats per MAX_BURST + 2 cycles.
- All outputs are registered except `valid` and `busy`, which decode registered state only.

## Structure
- Shared package `arb_pkg` holds:
  - state enum {IDLE, GRANT, GAP}
  - N_REQ, PRIO_W, AGE_W defaults
  - EFF_W = max(PRIO_W, AGE_W) + 1
- Sub-module `arb_pick` is purely combinational:
  - inputs: req, eff vector, rr_ptr
  - outputs: winner index and any-valid flag
- The top level holds the FSM, age counters, beat counter and rr_ptr.

## Test plan
- Single requester: req = 3'b010 at cycle 0 → gnt = 3'b010, owner = 1 after the first edge. 8 beats → gnt = 0 on the 8th beat edge, GAP, then re-grant 2 cycles later if req is still high.
- Priority win: prios = {3'd1, 3'd5, 3'd2}, req = 3'b111 from reset → source 1 granted first.
- Aging: prios = {0, 0, 7}, req = 3'b101 held, source 0 re-requests continuously with release after 1 beat → source 2 is granted once age[2] + 0 exceeds 7, i.e. within 8 waiting cycles, never starved.
- Round-robin tie: equal prios, req = 3'b111, release every grant → grant order 0, 1, 2, 0.
- Early termination: owner drops req mid-burst at beat 3 → gnt = 0 next edge. release asserted with beat on the last beat → exactly one GAP cycle.
- Async reset: assert rst mid-GRANT between edges → gnt, owner, busy = 0 immediately. After deassert, a tie goes to source 0.
